// File: rtl/perf_snapshot_fifo.sv
// Captures perf-monitor counters on measurement_done, computes utilization and queues records for the CSR bridge.
// Define PERF_SNAP_UTIL_EN to include the sequential divider; without it snap_util is always 0.
module perf_snapshot_fifo #(
  parameter int COUNTER_WIDTH = 32,
  parameter int DEPTH         = 4,
  parameter int DROP_WIDTH    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     measurement_done,
  input  logic [COUNTER_WIDTH-1:0] total_cycles_count,
  input  logic [COUNTER_WIDTH-1:0] active_cycles_count,
  input  logic [COUNTER_WIDTH-1:0] idle_cycles_count,
  input  logic [COUNTER_WIDTH-1:0] cache_hit_count,
  input  logic [COUNTER_WIDTH-1:0] cache_miss_count,
  input  logic                     clear,
  input  logic                     snap_ready,
  output logic                     snap_valid,
  output logic [COUNTER_WIDTH-1:0] snap_total,
  output logic [COUNTER_WIDTH-1:0] snap_active,
  output logic [COUNTER_WIDTH-1:0] snap_idle,
  output logic [COUNTER_WIDTH-1:0] snap_hits,
  output logic [COUNTER_WIDTH-1:0] snap_misses,
  output logic [8:0]               snap_util,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic [DROP_WIDTH-1:0]    drop_count,
  output logic                     busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIV  = 2'd1,
    PUSH = 2'd2
  } state_e;

  typedef struct packed {
    logic [COUNTER_WIDTH-1:0] total;
    logic [COUNTER_WIDTH-1:0] active;
    logic [COUNTER_WIDTH-1:0] idle;
    logic [COUNTER_WIDTH-1:0] hits;
    logic [COUNTER_WIDTH-1:0] misses;
    logic [8:0]               util;
  } rec_t;

  state_e                state_r, state_s;
  rec_t                  cap_r;
  rec_t                  rec_s;
  rec_t                  head_s;
  rec_t                  mem_r [DEPTH];
  logic [PW-1:0]         wr_ptr_r, rd_ptr_r;
  logic [LW-1:0]         level_r, level_s;
  logic                  valid_r;
  logic [DROP_WIDTH-1:0] drop_r, drop_s;
  logic [DROP_WIDTH:0]   drop_sum_s;
  logic [1:0]            drop_inc_s;
  logic                  capture_s, pop_s, full_s, push_s, push_ok_s;
  logic                  push_drop_s, strobe_drop_s;
  logic                  fast_s, div_done_s;
  logic [8:0]            util_s;

`ifdef PERF_SNAP_UTIL_EN
  localparam int N   = COUNTER_WIDTH + 8;
  localparam int DCW = $clog2(N + 1);

  // Dividend shifts out of dq_r's top while quotient bits shift in at the bottom.
  logic [COUNTER_WIDTH-1:0] rem_r, rem_s;
  logic [N-1:0]             dq_r;
  logic [DCW-1:0]           cnt_r;
  logic [COUNTER_WIDTH:0]   trial_s;
  logic                     fit_s;

  // One restoring-division step on the current partial remainder.
  always_comb begin
    trial_s = {rem_r, dq_r[N-1]};
    fit_s   = (trial_s >= {1'b0, cap_r.total});
    if (fit_s) begin
      rem_s = trial_s[COUNTER_WIDTH-1:0] - cap_r.total;
    end else begin
      rem_s = trial_s[COUNTER_WIDTH-1:0];
    end
    fast_s     = (total_cycles_count == {COUNTER_WIDTH{1'b0}});
    div_done_s = (cnt_r == DCW'(N - 1));
    util_s     = dq_r[8:0];
  end

  // Divider state: loaded on capture, stepped once per DIV cycle.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      rem_r <= '0;
      dq_r  <= '0;
      cnt_r <= '0;
    end else if (capture_s) begin
      rem_r <= '0;
      cnt_r <= '0;
      if (fast_s) begin
        dq_r <= '0;
      end else begin
        dq_r <= {active_cycles_count, 8'd0};
      end
    end else if (state_r == DIV) begin
      rem_r <= rem_s;
      dq_r  <= {dq_r[N-2:0], fit_s};
      cnt_r <= cnt_r + DCW'(1);
    end
  end
`else
  // Without the divider every capture goes straight to PUSH with zero utilization.
  always_comb begin
    fast_s     = 1'b1;
    div_done_s = 1'b1;
    util_s     = 9'd0;
  end
`endif

  // Capture-path next state; clear overrides any transition.
  always_comb begin
    state_s = state_r;
    if (clear) begin
      state_s = IDLE;
    end else begin
      case (state_r)
        IDLE: begin
          if (measurement_done) begin
            state_s = fast_s ? PUSH : DIV;
          end else begin
            state_s = IDLE;
          end
        end
        DIV: begin
          if (div_done_s) begin
            state_s = PUSH;
          end else begin
            state_s = DIV;
          end
        end
        PUSH:    state_s = IDLE;
        default: state_s = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FIFO handshake, level and drop-count arithmetic.
  always_comb begin
    capture_s     = (state_r == IDLE) && measurement_done;
    strobe_drop_s = (state_r != IDLE) && measurement_done;
    pop_s         = valid_r && snap_ready;
    full_s        = (level_r == LW'(DEPTH));
    push_s        = (state_r == PUSH);
    push_ok_s     = push_s && (!full_s || pop_s);
    push_drop_s   = push_s && !push_ok_s;
    rec_s         = cap_r;
    rec_s.util    = util_s;
    head_s        = mem_r[rd_ptr_r];
    case ({push_ok_s, pop_s})
      2'b10:   level_s = level_r + LW'(1);
      2'b01:   level_s = level_r - LW'(1);
      default: level_s = level_r;
    endcase
    drop_inc_s = {1'b0, push_drop_s} + {1'b0, strobe_drop_s};
    drop_sum_s = {1'b0, drop_r} + {{(DROP_WIDTH-1){1'b0}}, drop_inc_s};
    if (drop_sum_s[DROP_WIDTH]) begin
      drop_s = '1;
    end else begin
      drop_s = drop_sum_s[DROP_WIDTH-1:0];
    end
  end

  // Capture register, FIFO storage, pointers, level and drop counter.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cap_r    <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      level_r  <= '0;
      valid_r  <= 1'b0;
      drop_r   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else begin
      if (capture_s) begin
        cap_r.total  <= total_cycles_count;
        cap_r.active <= active_cycles_count;
        cap_r.idle   <= idle_cycles_count;
        cap_r.hits   <= cache_hit_count;
        cap_r.misses <= cache_miss_count;
        cap_r.util   <= 9'd0;
      end
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= rec_s;
        wr_ptr_r        <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      level_r <= level_s;
      valid_r <= (level_s != '0);
      drop_r  <= drop_s;
    end
  end

  assign snap_valid  = valid_r;
  assign snap_total  = head_s.total;
  assign snap_active = head_s.active;
  assign snap_idle   = head_s.idle;
  assign snap_hits   = head_s.hits;
  assign snap_misses = head_s.misses;
  assign snap_util   = head_s.util;
  assign fifo_level  = level_r;
  assign drop_count  = drop_r;
  assign busy        = (state_r != IDLE);

endmodule
